sm_stream_accumulator: RTL and testbench
========================================

Name: sm_stream_accumulator

Overview:
- Sequential, parametrised successor of the team's combinational sign-magnitude fixed-point adder.
- Accumulates a stream of iLen sign-magnitude values onto a start value (neuron bias) and returns one sum per job with a sticky overflow flag.
- Sits in the DNN datapath between the weight×activation multiplier stream and the activation stage.

Parameters:
- WIDTH, 31, total word width: bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude.
- LEN_W, 10, width of the element-count field (max 1023 elements per job).

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iStart  input  1  job request; sampled only in IDLE.
- iBias  input  WIDTH  accumulator start value, captured with iStart.
- iLen  input  LEN_W  number of elements in the job, captured with iStart.
- iValid  input  1  iData is valid.
- iData  input  WIDTH  sign-magnitude element.
- oReady  output  1  element accepted this cycle when iValid & oReady.
- oValid  output  1  oSum/oOverflow are valid.
- iReady  input  1  downstream accepts the result.
- oSum  output  WIDTH  accumulated result.
- oOverflow  output  1  sticky overflow for the job.
- oBusy  output  1  high whenever state != IDLE.

Behaviour:
- Encoding: sign-magnitude. SENTINEL = sign 1, magnitude 0; it is the overflow marker, never a numeric value. Zero is always +0.
- Reset: state IDLE; acc = +0; count = 0; ovf = 0. Outputs oReady = 0, oValid = 0, oSum = 0, oOverflow = 0, oBusy = 0. Reset mid-job aborts the job with no output.
- FSM states:
  - IDLE: on iStart, acc <= iBias, count <= iLen, ovf <= (iBias == SENTINEL). Next state is ACCUM if iLen != 0, otherwise DONE.
  - ACCUM: oReady = 1. On each iValid & oReady, acc <= add(acc, iData) and count decrements. When the handshake occurs with count == 1, next state is DONE.
  - DONE: oValid = 1, oSum = acc, oOverflow = ovf. Hold until iReady, then return to IDLE. oSum/oOverflow stay stable while oValid & !iReady.
- iStart outside IDLE is ignored. iValid outside ACCUM is ignored (oReady = 0).
- Throughput: one element per cycle. Latency from the last accepted element to oValid is 1 cycle. With iLen = 0, oValid appears 1 cycle after iStart with oSum = iBias.
- add(a, b) rules:
  - Same sign: magnitudes are added with one carry bit. A carry sets overflow.
  - Different sign: the smaller magnitude is subtracted from the larger; the result takes the sign of the larger. Equal magnitudes give +0.
  - If either operand is SENTINEL, the result overflows.
- Overflow (default build): ovf <= 1 and acc <= SENTINEL. Overflow is sticky, so later elements leave acc = SENTINEL. The remaining elements are still consumed so the stream stays aligned.
- Simultaneous DONE→IDLE and iStart in the same cycle: iStart is ignored; a new job needs iStart while in IDLE.

Optional Feature:
- Macro SM_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to the largest magnitude with the sign of the overflowing same-sign sum, and ovf is set. Accumulation continues from the clamped value (not sticky), so later opposite-sign elements reduce it. A SENTINEL operand still forces acc = SENTINEL for the rest of the job.
- Undefined: sticky SENTINEL behaviour as above.

Decomposition:
- Package sm_fixed_pkg holds:
  - WIDTH default and MAG_W = WIDTH-1;
  - SENTINEL and MAX_POS/MAX_NEG constants;
  - state typedef (IDLE, ACCUM, DONE).
- Sub-module sm_add_core: combinational add(a, b) returning sum and overflow, with the saturation mux under SM_ACC_SATURATE_EN. The top level holds the FSM, counter and registers.

Test Plan:
- Basic sum: bias +0x00000003, iLen = 2, data −0x00000005 then +0x0000000A → oSum = +0x00000008, oOverflow = 0, oValid one cycle after the 2nd handshake.
- Cancellation: bias +0x00000007, data −0x00000007 → oSum = 0x00000000 (+0, not SENTINEL), oOverflow = 0.
- Overflow, default build: bias +0x3FFFFFFF, data +0x00000001, then −0x00000005 (iLen = 2) → oSum = 0x40000000, oOverflow = 1, both elements accepted. With SM_ACC_SATURATE_EN the same stimulus gives oSum = +0x3FFFFFFA, oOverflow = 1.
- iLen = 0 with bias −0x00000010 → oValid the cycle after iStart, oSum = 0x40000010. iValid pulses during the job are ignored.
- Backpressure and gaps: iValid gaps during ACCUM with iReady held low for 5 cycles in DONE → oSum stable, no extra accepts, IDLE after iReady. A second iStart mid-job is ignored.
- Reset mid-ACCUM, asserted asynchronously between clock edges → outputs 0 immediately. A fresh job then returns the correct sum.

Source files
------------

// File: rtl/sm_fixed_pkg.sv
//------------------------------------------------------------------------------
// Module   : sm_fixed_pkg
// Purpose  : Shared constants and types for the sign-magnitude stream
//            accumulator: default word width, SENTINEL/MAX encodings and the
//            controller state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sm_fixed_pkg;

   localparam int WIDTH_DEF = 31;
   localparam int MAG_W     = WIDTH_DEF - 1;

   // Sign set with zero magnitude is reserved as the overflow marker.
   localparam logic [WIDTH_DEF-1:0] SENTINEL = {1'b1, {MAG_W{1'b0}}};
   localparam logic [WIDTH_DEF-1:0] MAX_POS  = {1'b0, {MAG_W{1'b1}}};
   localparam logic [WIDTH_DEF-1:0] MAX_NEG  = {1'b1, {MAG_W{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sm_stream_accumulator_if.sv
//------------------------------------------------------------------------------
// Module   : sm_stream_accumulator_if
// Purpose  : Job/element/result handshake bundle of the stream accumulator.
// Ports    : master - job source, element stream and result sink side
//            slave  - accumulator side
//            iStart/iBias/iLen : job request; iValid/iData/oReady : elements;
//            oValid/oSum/oOverflow/iReady : result; oBusy : activity flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sm_stream_accumulator_if
   import sm_fixed_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = 10
);
   logic             iStart;
   logic [WIDTH-1:0] iBias;
   logic [LEN_W-1:0] iLen;
   logic             iValid;
   logic [WIDTH-1:0] iData;
   logic             oReady;
   logic             oValid;
   logic             iReady;
   logic [WIDTH-1:0] oSum;
   logic             oOverflow;
   logic             oBusy;

   modport master (
      output iStart, iBias, iLen, iValid, iData, iReady,
      input  oReady, oValid, oSum, oOverflow, oBusy
   );

   modport slave (
      input  iStart, iBias, iLen, iValid, iData, iReady,
      output oReady, oValid, oSum, oOverflow, oBusy
   );
endinterface

`default_nettype wire

// File: rtl/sm_stream_accumulator_add_core.sv
//------------------------------------------------------------------------------
// Module   : sm_add_core
// Purpose  : Combinational sign-magnitude add with overflow detection.
//            Overflow result is SENTINEL, or with SM_ACC_SATURATE_EN defined
//            a same-sign carry clamps to the largest magnitude instead.
//            A SENTINEL operand always yields SENTINEL.
// Ports    : i_a, i_b - operands; o_sum - result; o_ovf - overflow occurred
// Macro    : SM_ACC_SATURATE_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm_add_core
   import sm_fixed_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  wire logic [WIDTH-1:0] i_a,
   input  wire logic [WIDTH-1:0] i_b,
   output logic      [WIDTH-1:0] o_sum,
   output logic                  o_ovf
);
   localparam int MW = WIDTH - 1;
   localparam logic [WIDTH-1:0] SENT = {1'b1, {MW{1'b0}}};

   logic          a_sgn, b_sgn;
   logic [MW-1:0] a_mag, b_mag;
   logic          a_sent, b_sent;
   logic [MW:0]   mag_sum;
   logic          a_ge_b;
   logic [MW-1:0] mag_diff;

   assign a_sgn    = i_a[WIDTH-1];
   assign b_sgn    = i_b[WIDTH-1];
   assign a_mag    = i_a[MW-1:0];
   assign b_mag    = i_b[MW-1:0];
   assign a_sent   = (i_a == SENT);
   assign b_sent   = (i_b == SENT);
   assign mag_sum  = {1'b0, a_mag} + {1'b0, b_mag};
   assign a_ge_b   = (a_mag >= b_mag);
   assign mag_diff = a_ge_b ? (a_mag - b_mag) : (b_mag - a_mag);

   always_comb begin
      o_ovf = 1'b0;
      o_sum = '0;
      if (a_sent || b_sent) begin
         o_ovf = 1'b1;
         o_sum = SENT;
      end else if (a_sgn == b_sgn) begin
         if (mag_sum[MW]) begin
            o_ovf = 1'b1;
`ifdef SM_ACC_SATURATE_EN
            o_sum = {a_sgn, {MW{1'b1}}};
`else
            o_sum = SENT;
`endif
         end else begin
            o_sum = {a_sgn, mag_sum[MW-1:0]};
         end
      end else if (mag_diff != '0) begin
         // Opposite signs: result follows the larger magnitude.
         o_sum = {a_ge_b ? a_sgn : b_sgn, mag_diff};
      end
      // Equal magnitudes of opposite sign fall through to +0.
   end
endmodule

`default_nettype wire

// File: rtl/sm_stream_accumulator.sv
//------------------------------------------------------------------------------
// Module   : sm_stream_accumulator
// Purpose  : Accumulates iLen sign-magnitude elements onto a bias and returns
//            one sum per job with a sticky overflow flag.
// Ports    : iClk - clock; iRst - asynchronous active-high reset
//            bus  - sm_stream_accumulator_if.slave (job, elements, result)
// Macro    : SM_ACC_SATURATE_EN selects clamping instead of sticky SENTINEL
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm_stream_accumulator
   import sm_fixed_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = 10
) (
   input wire logic iClk,
   input wire logic iRst,
   sm_stream_accumulator_if.slave bus
);
   localparam logic [WIDTH-1:0] SENT    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             oovf_q, oovf_d;
   logic [WIDTH-1:0] sum_q, sum_d;

   logic [WIDTH-1:0] add_sum;
   logic             add_ovf;

   sm_add_core #(.WIDTH(WIDTH)) u_add (
      .i_a   (acc_q),
      .i_b   (bus.iData),
      .o_sum (add_sum),
      .o_ovf (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.iStart) begin
               acc_d   = bus.iBias;
               count_d = bus.iLen;
               ovf_d   = (bus.iBias == SENT);
               state_d = (bus.iLen != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            // oReady is high throughout ACCUM, so iValid alone is the handshake.
            if (bus.iValid) begin
               acc_d   = add_sum;
               ovf_d   = ovf_q | add_ovf;
               count_d = count_q - LEN_ONE;
               if (count_q == LEN_ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // iStart here is deliberately dropped; jobs only start from IDLE.
            if (bus.iReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      ready_d = (state_d == ACCUM);
      valid_d = (state_d == DONE);
      busy_d  = (state_d != IDLE);
      sum_d   = (state_d == DONE) ? acc_d : '0;
      oovf_d  = (state_d == DONE) & ovf_d;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         oovf_q  <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         oovf_q  <= oovf_d;
         sum_q   <= sum_d;
      end
   end

   assign bus.oReady    = ready_q;
   assign bus.oValid    = valid_q;
   assign bus.oBusy     = busy_q;
   assign bus.oOverflow = oovf_q;
   assign bus.oSum      = sum_q;
endmodule

`default_nettype wire

// File: tb/tb_sm_stream_accumulator.sv
//------------------------------------------------------------------------------
// Module   : tb_sm_stream_accumulator
// Purpose  : Directed self-checking bench for sm_stream_accumulator, with an
//            integer-arithmetic reference model and literal expectations.
// Ports    : none
// Macro    : SM_ACC_SATURATE_EN selects the clamping expectations
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_stream_accumulator;
   localparam int     W    = 31;
   localparam int     MW   = W - 1;
   localparam int     LW   = 10;
   localparam longint MAXM = 64'h3FFF_FFFF;
   localparam logic [W-1:0] SENT = 31'h4000_0000;

`ifdef SM_ACC_SATURATE_EN
   localparam logic [W-1:0] OVF_POS_EXP = 31'h3FFF_FFFA;
   localparam logic [W-1:0] OVF_NEG_EXP = 31'h7FFF_FFFF;
`else
   localparam logic [W-1:0] OVF_POS_EXP = 31'h4000_0000;
   localparam logic [W-1:0] OVF_NEG_EXP = 31'h4000_0000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   accepts = 0;

   sm_stream_accumulator_if #(.WIDTH(W), .LEN_W(LW)) bus();

   sm_stream_accumulator #(.WIDTH(W), .LEN_W(LW)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: values as plain signed integers
   typedef struct {
      int     phase;   // 0 idle, 1 collecting, 2 result shown
      int     left;
      bit     sent;
      bit     ovf;
      longint acc;
   } mdl_t;

   mdl_t m;

   function automatic longint sval(input logic [W-1:0] x);
      return x[W-1] ? -longint'(x[MW-1:0]) : longint'(x[MW-1:0]);
   endfunction

   function automatic logic [W-1:0] enc(input mdl_t s);
      if (s.sent)     return SENT;
      if (s.acc < 0)  return {1'b1, MW'(-s.acc)};
      return {1'b0, MW'(s.acc)};
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic st, input logic [W-1:0] bias,
                                 input logic [LW-1:0] len, input logic v,
                                 input logic [W-1:0] d, input logic rdy);
      mdl_t   n = s;
      longint t;
      case (s.phase)
         0: if (st) begin
            n.sent  = (bias == SENT);
            n.ovf   = n.sent;
            n.acc   = n.sent ? 0 : sval(bias);
            n.left  = int'(len);
            n.phase = (len != 0) ? 1 : 2;
         end
         1: if (v) begin
            if (s.sent || d == SENT) begin
               n.sent = 1'b1;
               n.ovf  = 1'b1;
            end else begin
               t = s.acc + sval(d);
               if (t > MAXM || t < -MAXM) begin
                  n.ovf = 1'b1;
`ifdef SM_ACC_SATURATE_EN
                  n.acc = (t > 0) ? MAXM : -MAXM;
`else
                  n.sent = 1'b1;
`endif
               end else begin
                  n.acc = t;
               end
            end
            n.left = n.left - 1;
            if (n.left == 0) n.phase = 2;
         end
         default: if (rdy) n.phase = 0;
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{phase: 0, left: 0, sent: 1'b0, ovf: 1'b0, acc: 0};
      else     m <= step(m, bus.iStart, bus.iBias, bus.iLen, bus.iValid, bus.iData, bus.iReady);
   end

   // Compare process: outputs checked against the model on every falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("m_busy",  bus.oBusy,  m.phase != 0);
         check("m_ready", bus.oReady, m.phase == 1);
         check("m_valid", bus.oValid, m.phase == 2);
         if (m.phase == 2) begin
            check("m_sum", bus.oSum,      enc(m));
            check("m_ovf", bus.oOverflow, m.ovf);
         end
         if (bus.iValid && bus.oReady) accepts++;
      end
   end

   // ---------------- stimulus helpers (drive 2 time units after the rising edge)
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic start_job(input logic [W-1:0] bias, input logic [LW-1:0] len);
      tick;
      accepts    = 0;
      bus.iStart = 1'b1;
      bus.iBias  = bias;
      bus.iLen   = len;
   endtask

   task automatic send(input logic [W-1:0] d);
      bit ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         tick;
         bus.iStart = 1'b0;
         bus.iValid = 1'b1;
         bus.iData  = d;
         ok = bus.oReady;
      end
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic gap(input logic st);
      tick;
      bus.iValid = 1'b0;
      bus.iStart = st;
      bus.iBias  = 31'h0000_0777;
      bus.iLen   = 10'd0;
   endtask

   task automatic finish_job(input string nm, input logic [W-1:0] es, input logic eo,
                             input int hold, input int exp_acc, input logic start_too);
      int w = 0;
      tick;
      bus.iStart = 1'b0;
      bus.iValid = 1'b0;
      bus.iReady = 1'b0;
      while (!bus.oValid && w < 40) begin
         tick;
         w++;
      end
      check({nm, "_latency"}, w, 0);
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) tick;
         check({nm, "_sum"}, bus.oSum, es);
         check({nm, "_ovf"}, bus.oOverflow, eo);
      end
      bus.iReady = 1'b1;
      bus.iStart = start_too;
      tick;
      bus.iReady = 1'b0;
      bus.iStart = 1'b0;
      check({nm, "_idle"}, bus.oBusy, 0);
      check({nm, "_accepts"}, accepts, exp_acc);
   endtask

   initial begin
      bus.iStart = 1'b0;
      bus.iBias  = '0;
      bus.iLen   = '0;
      bus.iValid = 1'b0;
      bus.iData  = '0;
      bus.iReady = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      check("rst_ready", bus.oReady, 0);
      check("rst_valid", bus.oValid, 0);
      check("rst_sum",   bus.oSum, 0);
      check("rst_ovf",   bus.oOverflow, 0);
      check("rst_busy",  bus.oBusy, 0);
      rst = 1'b0;

      // +3 - 5 + 10 = +8
      start_job(31'h0000_0003, 10'd2);
      send(31'h4000_0005);
      send(31'h0000_000A);
      finish_job("basic", 31'h0000_0008, 1'b0, 0, 2, 1'b0);

      // +7 - 7 = +0, never SENTINEL
      start_job(31'h0000_0007, 10'd1);
      send(31'h4000_0007);
      finish_job("cancel", 31'h0000_0000, 1'b0, 0, 1, 1'b0);

      // positive carry-out, remaining element still consumed
      start_job(31'h3FFF_FFFF, 10'd2);
      send(31'h0000_0001);
      send(31'h4000_0005);
      finish_job("ovf_pos", OVF_POS_EXP, 1'b1, 0, 2, 1'b0);

      // negative carry-out
      start_job(31'h7FFF_FFFF, 10'd1);
      send(31'h4000_0001);
      finish_job("ovf_neg", OVF_NEG_EXP, 1'b1, 0, 1, 1'b0);

      // zero-length job with stray iValid before and during it
      tick;
      bus.iValid = 1'b1;
      bus.iData  = 31'h0000_0003;
      start_job(31'h4000_0010, 10'd0);
      finish_job("len0", 31'h4000_0010, 1'b0, 0, 0, 1'b0);

      // gaps, a stray mid-job iStart, 5 cycles of backpressure, iStart on exit
      start_job(31'h0000_0100, 10'd3);
      send(31'h0000_0010);
      gap(1'b1);
      gap(1'b0);
      send(31'h4000_0020);
      gap(1'b0);
      send(31'h0000_0005);
      finish_job("backpressure", 31'h0000_00F5, 1'b0, 5, 3, 1'b1);

      // SENTINEL bias poisons the whole job
      start_job(SENT, 10'd1);
      send(31'h0000_0001);
      finish_job("sent_bias", SENT, 1'b1, 0, 1, 1'b0);

      // asynchronous reset in the middle of a job
      start_job(31'h0000_0001, 10'd3);
      send(31'h0000_0002);
      tick;
      bus.iValid = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", bus.oReady, 0);
      check("arst_valid", bus.oValid, 0);
      check("arst_sum",   bus.oSum, 0);
      check("arst_ovf",   bus.oOverflow, 0);
      check("arst_busy",  bus.oBusy, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // -16 + 4 - 1 = -13
      start_job(31'h4000_0010, 10'd2);
      send(31'h0000_0004);
      send(31'h4000_0001);
      finish_job("post_rst", 31'h4000_000D, 1'b0, 0, 2, 1'b0);

      repeat (2) tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
